// File: rtl/iram_fetch.sv
// Instruction-fetch reader for the registered (1-cycle) instruction RAM port.
// Ports: clk_i/rst_n_i clock and async active-low reset; run_i fetch enable;
//   jump_i/jump_addr_i redirect; rd_en_o/rd_addr_o/rd_data_i RAM read port
//   (word address); inst_valid_o/inst_ready_i/inst_o/pc_o decode handshake.
module iram_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            run_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_addr_i,
    output logic            rd_en_o,
    output logic [XLEN-1:0] rd_addr_o,
    input  logic [XLEN-1:0] rd_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [1:0]      count;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_inst;
    logic [XLEN-1:0] tail_pc;
    logic [XLEN-1:0] tail_inst;

    logic            deq;
    logic            push;
    logic            issue;
    logic [2:0]      occupancy;
    logic [XLEN-1:0] jump_pc;
    logic [XLEN-1:0] fetch_pc;

    assign jump_pc  = jump_addr_i & ~XLEN'(3);
    assign fetch_pc = jump_i ? jump_pc : pc;

    assign inst_valid_o = (count != 2'd0);
    assign deq          = inst_valid_o & inst_ready_i;
    // A redirect discards the response arriving this cycle.
    assign push         = inflight & ~jump_i;

    // Buffered plus outstanding words after this cycle's dequeue; keeping it
    // below 2 before issuing makes a push into a full buffer impossible.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};

    // Gated by reset so the RAM sees no read while reset is held.
    assign issue = rst_n_i & run_i & (jump_i | (occupancy < 3'd2));

    assign rd_en_o   = issue;
    assign rd_addr_o = fetch_pc >> 2;
    assign inst_o    = head_inst;
    assign pc_o      = head_pc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= 2'd0;
            head_pc     <= '0;
            head_inst   <= '0;
            tail_pc     <= '0;
            tail_inst   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                pc          <= fetch_pc + XLEN'(4);
            end else if (jump_i) begin
                pc <= jump_pc;
            end

            if (jump_i) begin
                count <= 2'd0;
            end else begin
                case (count)
                    2'd0: begin
                        if (push) begin
                            head_pc   <= inflight_pc;
                            head_inst <= rd_data_i;
                            count     <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (push && deq) begin
                            head_pc   <= inflight_pc;
                            head_inst <= rd_data_i;
                        end else if (push) begin
                            tail_pc   <= inflight_pc;
                            tail_inst <= rd_data_i;
                            count     <= 2'd2;
                        end else if (deq) begin
                            count <= 2'd0;
                        end
                    end
                    default: begin
                        if (deq) begin
                            head_pc   <= tail_pc;
                            head_inst <= tail_inst;
                            if (push) begin
                                tail_pc   <= inflight_pc;
                                tail_inst <= rd_data_i;
                            end else begin
                                count <= 2'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/iram_fetch.md
Name: iram_fetch

Overview:
- Instruction-fetch reader for the instruction RAM read port.
- Keeps the program counter and issues word reads into the 1-cycle-latency registered RAM read port.
- Captures returned words into a 2-entry skid buffer and presents {pc, instruction} to the decode stage over a valid/ready handshake.
- Handles control-flow redirects by flushing queued and in-flight fetches.

Parameters:
- XLEN, 32: address/data width.
- RESET_PC, 32'h0000_0000: byte address of the first fetch after reset; bits [1:0] must be 0.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- run_i  in  1  fetch enable; low halts new reads (held low while the loader writes the RAM).
- jump_i  in  1  redirect request, single-cycle pulse.
- jump_addr_i  in  XLEN  redirect byte address; bits [1:0] ignored (treated as 0).
- rd_en_o  out  1  RAM read enable.
- rd_addr_o  out  XLEN  RAM word address = {2'b00, addr[XLEN-1:2]}.
- rd_data_i  in  XLEN  RAM read data, valid the cycle after rd_en_o.
- inst_valid_o  out  1  buffer head valid.
- inst_ready_i  in  1  decode accepts the head.
- inst_o  out  XLEN  head instruction word.
- pc_o  out  XLEN  head byte address.

Behaviour:
- Reset (async, rst_n_i low):
  - pc=RESET_PC, buffer count=0, inflight=0.
  - inst_valid_o=0, inst_o=0, pc_o=0.
  - rd_en_o=0 while reset is asserted.
- State: pc (next byte address to fetch), inflight flag plus inflight_pc (one outstanding read), 2-entry FIFO of {pc, inst} with count 0..2.
- Dequeue: deq = inst_valid_o & inst_ready_i. inst_valid_o = (count != 0). inst_o/pc_o show the head entry. Both are stable while valid and not ready.
- Issue rule, normal cycle: rd_en_o = run_i & (count + inflight - deq < 2).
  - rd_addr_o is derived from pc.
  - On issue: inflight<=1, inflight_pc<=pc, pc<=pc+4 (wraps modulo 2^XLEN).
  - No issue: inflight<=0.
- Response: when inflight=1, the cycle's rd_data_i is pushed as {inflight_pc, rd_data_i}. Push and pop in the same cycle are allowed; count changes by push-deq.
- Latency: read issued in cycle N, data on rd_data_i in N+1, inst_valid_o high in N+2.
- Throughput: one instruction per cycle with inst_ready_i held high.
- Backpressure: the issue rule guarantees no push ever exceeds depth 2. Overflow is impossible by construction; the bench asserts count<=2.
- Redirect (jump_i=1), priority over everything:
  - FIFO flushed (count<=0). A same-cycle deq counts as a completed transfer.
  - This cycle's rd_data_i response is discarded.
  - rd_en_o = run_i, rd_addr_o derived from jump_addr_i & ~3.
  - If issued: inflight<=1, inflight_pc<=jump_addr_i&~3, pc<=(jump_addr_i&~3)+4. Otherwise pc<=jump_addr_i&~3, inflight<=0.
- run_i low:
  - No new reads; the outstanding response still lands in the FIFO.
  - The FIFO drains normally; pc holds.
  - Fetch resumes at pc the first cycle run_i is high.
- jump_i while run_i low: flush and load pc; no read is issued.
- Reset mid-operation: everything returns to reset values immediately. A stale RAM response after release is ignored because inflight=0.

Test Plan:
- Release reset with RESET_PC=0x100, run_i=1, ready=1, RAM word k=0xA000_0000+k. Required:
  - rd_addr_o sequence 0x40, 0x41, 0x42…
  - First inst_valid_o 2 cycles after the first rd_en_o, pc_o=0x100/inst=0xA000_0040.
  - One instruction per cycle thereafter.
- Hold inst_ready_i=0 for 6 cycles mid-stream. Required:
  - rd_en_o drops once count+inflight reaches 2.
  - Head pc_o/inst_o stay stable.
  - No word is lost or duplicated on resume; the pc sequence is contiguous.
- jump_i with jump_addr_i=0x2003 while count=2 and a read is in flight. Required:
  - Same-cycle rd_addr_o=0x800.
  - Next valid head is pc_o=0x2000 two cycles later.
  - Old in-flight data is never presented.
- Drop run_i for 4 cycles with ready=1. Required:
  - No rd_en_o.
  - The outstanding response is delivered, then inst_valid_o=0.
  - Resume fetches continue at the next sequential pc.
- Set pc near 0xFFFF_FFF8 via jump. Required: fetched pcs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- Assert rst_n_i low with count=2 and inflight=1, while rd_data_i keeps old data after release. Required:
  - inst_valid_o=0 immediately.
  - The first fetch after release is RESET_PC.
  - The stale word is never pushed.
